// File: rtl/fifo_queue_param_if.sv
// Push/pop handshake, flush and status bundle for fifo_queue_param.
// master = producer/consumer side, slave = the queue itself.
interface fifo_queue_param_if #(
    parameter int DATA_W = 32,
    parameter int OCC_W  = 4
);
    logic              flush_in;
    logic [DATA_W-1:0] request_in;
    logic              request_valid_in;
    logic              issue_ack_out;
    logic [DATA_W-1:0] request_out;
    logic              request_valid_out;
    logic              issue_ack_in;
    logic              is_empty_out;
    logic              is_full_out;
    logic              is_almost_full_out;
    logic              is_almost_empty_out;
    logic [OCC_W-1:0]  occupancy_out;
    logic [15:0]       reject_ctr_out;

    modport master (
        output flush_in, request_in, request_valid_in, issue_ack_in,
        input  issue_ack_out, request_out, request_valid_out,
               is_empty_out, is_full_out, is_almost_full_out,
               is_almost_empty_out, occupancy_out, reject_ctr_out
    );

    modport slave (
        input  flush_in, request_in, request_valid_in, issue_ack_in,
        output issue_ack_out, request_out, request_valid_out,
               is_empty_out, is_full_out, is_almost_full_out,
               is_almost_empty_out, occupancy_out, reject_ctr_out
    );
endinterface

// File: rtl/fifo_queue_param.sv
// Single-clock first-word-fall-through FIFO of arbitrary depth with occupancy,
// threshold flags, synchronous flush, optional full bypass and a saturating reject counter.
module fifo_queue_param #(
    parameter int    QUEUE_SIZE                 = 8,
    parameter int    QUEUE_PTR_WIDTH_IN_BITS    = 3,
    parameter int    SINGLE_ENTRY_WIDTH_IN_BITS = 32,
    parameter string STORAGE_TYPE               = "LUTRAM",
    parameter int    ALMOST_FULL_THRESHOLD      = 6,
    parameter int    ALMOST_EMPTY_THRESHOLD     = 2,
    parameter bit    ALLOW_FULL_BYPASS          = 1'b1
) (
    input logic               clk_in,
    input logic               reset_in,
    fifo_queue_param_if.slave bus
);

    localparam int PTR_W  = QUEUE_PTR_WIDTH_IN_BITS;
    localparam int OCC_W  = QUEUE_PTR_WIDTH_IN_BITS + 1;
    localparam int DATA_W = SINGLE_ENTRY_WIDTH_IN_BITS;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(QUEUE_SIZE - 1);
    localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(QUEUE_SIZE);
    localparam logic [OCC_W-1:0] AF_LVL   = OCC_W'(ALMOST_FULL_THRESHOLD);
    localparam logic [OCC_W-1:0] AE_LVL   = OCC_W'(ALMOST_EMPTY_THRESHOLD);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [15:0]       reject_ctr;
    logic [DATA_W-1:0] head;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              reject;

    // Explicit wrap so any depth works, not only powers of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign empty = (occ == '0);
    assign full  = (occ == FULL_LVL);
    assign pop   = bus.issue_ack_in & ~empty & ~bus.flush_in;
    // reset_in gates the ack so no push is reported while reset is held.
    assign push  = ~reset_in & bus.request_valid_in & ~bus.flush_in
                 & (~full | (ALLOW_FULL_BYPASS & pop));
    assign reject = bus.request_valid_in & ~push & ~bus.flush_in;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            reject_ctr <= '0;
        end else begin
            if (reject) begin
                reject_ctr <= sat_inc(reject_ctr);
            end
            if (bus.flush_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_next(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_next(rd_ptr);
                end
                case ({push, pop})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end
        end
    end

    // Storage holds data only and is never reset; both styles read asynchronously.
    generate
        if (STORAGE_TYPE == "FLOPS") begin : g_flops
            logic [DATA_W-1:0] regs [QUEUE_SIZE];

            always_ff @(posedge clk_in) begin
                for (int i = 0; i < QUEUE_SIZE; i++) begin
                    if (push && (wr_ptr == PTR_W'(i))) begin
                        regs[i] <= bus.request_in;
                    end
                end
            end

            always_comb begin
                head = '0;
                for (int i = 0; i < QUEUE_SIZE; i++) begin
                    if (rd_ptr == PTR_W'(i)) begin
                        head = regs[i];
                    end
                end
            end
        end else begin : g_lutram
            logic [DATA_W-1:0] mem [QUEUE_SIZE];

            always_ff @(posedge clk_in) begin
                if (push) begin
                    mem[wr_ptr] <= bus.request_in;
                end
            end

            assign head = mem[rd_ptr];
        end
    endgenerate

    assign bus.issue_ack_out       = push;
    assign bus.request_out         = empty ? '0 : head;
    assign bus.request_valid_out   = ~empty;
    assign bus.is_empty_out        = empty;
    assign bus.is_full_out         = full;
    assign bus.is_almost_full_out  = (occ >= AF_LVL);
    assign bus.is_almost_empty_out = (occ <= AE_LVL);
    assign bus.occupancy_out       = occ;
    assign bus.reject_ctr_out      = reject_ctr;

endmodule

// File: tb/tb_fifo_queue_param.sv
// Drives two queue configurations (depth 8 with bypass, depth 5 without) with the same
// stimulus and compares every cycle against a queue-based reference model.
module tb_fifo_queue_param;

    logic clk_in = 1'b0;
    logic reset_in;

    always #5 clk_in = ~clk_in;

    fifo_queue_param_if #(.DATA_W(32), .OCC_W(4)) bus_a ();
    fifo_queue_param_if #(.DATA_W(32), .OCC_W(4)) bus_b ();

    fifo_queue_param #(
        .QUEUE_SIZE(8), .QUEUE_PTR_WIDTH_IN_BITS(3), .SINGLE_ENTRY_WIDTH_IN_BITS(32),
        .STORAGE_TYPE("LUTRAM"), .ALMOST_FULL_THRESHOLD(6), .ALMOST_EMPTY_THRESHOLD(2),
        .ALLOW_FULL_BYPASS(1'b1)
    ) dut_a (
        .clk_in(clk_in), .reset_in(reset_in), .bus(bus_a)
    );

    fifo_queue_param #(
        .QUEUE_SIZE(5), .QUEUE_PTR_WIDTH_IN_BITS(3), .SINGLE_ENTRY_WIDTH_IN_BITS(32),
        .STORAGE_TYPE("FLOPS"), .ALMOST_FULL_THRESHOLD(4), .ALMOST_EMPTY_THRESHOLD(1),
        .ALLOW_FULL_BYPASS(1'b0)
    ) dut_b (
        .clk_in(clk_in), .reset_in(reset_in), .bus(bus_b)
    );

    typedef struct packed {
        logic        ack;
        logic [31:0] dout;
        logic        vld;
        logic        emp;
        logic        ful;
        logic        af;
        logic        ae;
        logic [3:0]  occ;
        logic [15:0] rej;
    } obs_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    int          rej_m [2];
    int          qsz   [2] = '{8, 5};
    bit          byp   [2] = '{1'b1, 1'b0};
    int          afl   [2] = '{6, 4};
    int          ael   [2] = '{2, 1};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int msize(input int k);
        return (k == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic logic [31:0] mfront(input int k);
        return (k == 0) ? q_a[0] : q_b[0];
    endfunction

    function automatic obs_t sample(input int k);
        obs_t o;
        if (k == 0) begin
            o = '{bus_a.issue_ack_out, bus_a.request_out, bus_a.request_valid_out,
                  bus_a.is_empty_out, bus_a.is_full_out, bus_a.is_almost_full_out,
                  bus_a.is_almost_empty_out, bus_a.occupancy_out, bus_a.reject_ctr_out};
        end else begin
            o = '{bus_b.issue_ack_out, bus_b.request_out, bus_b.request_valid_out,
                  bus_b.is_empty_out, bus_b.is_full_out, bus_b.is_almost_full_out,
                  bus_b.is_almost_empty_out, bus_b.occupancy_out, bus_b.reject_ctr_out};
        end
        return o;
    endfunction

    task automatic model_clear(input bit with_rej);
        q_a.delete();
        q_b.delete();
        if (with_rej) begin
            rej_m[0] = 0;
            rej_m[1] = 0;
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic [31:0] d, input logic a);
        bus_a.flush_in = f; bus_a.request_valid_in = v; bus_a.request_in = d; bus_a.issue_ack_in = a;
        bus_b.flush_in = f; bus_b.request_valid_in = v; bus_b.request_in = d; bus_b.issue_ack_in = a;
    endtask

    // Compare one instance against the model for the current inputs, then advance the model.
    task automatic check_step(input int k, input logic f, input logic v, input logic [31:0] d,
                              input logic a);
        obs_t o;
        int   n;
        bit   pop;
        bit   push;
        o    = sample(k);
        n    = msize(k);
        pop  = a && (n != 0) && !f;
        push = v && !f && ((n != qsz[k]) || (byp[k] && pop));
        check_val($sformatf("ack%0d", k), 32'(o.ack), 32'(push));
        check_val($sformatf("dout%0d", k), o.dout, (n == 0) ? 32'h0 : mfront(k));
        check_val($sformatf("vld%0d", k), 32'(o.vld), 32'(n != 0));
        check_val($sformatf("empty%0d", k), 32'(o.emp), 32'(n == 0));
        check_val($sformatf("full%0d", k), 32'(o.ful), 32'(n == qsz[k]));
        check_val($sformatf("afull%0d", k), 32'(o.af), 32'(n >= afl[k]));
        check_val($sformatf("aempty%0d", k), 32'(o.ae), 32'(n <= ael[k]));
        check_val($sformatf("occ%0d", k), 32'(o.occ), 32'(n));
        check_val($sformatf("rej%0d", k), 32'(o.rej), 32'(rej_m[k]));
        if (v && !push && !f && rej_m[k] < 65535) rej_m[k]++;
        if (f) begin
            if (k == 0) q_a.delete(); else q_b.delete();
        end else begin
            if (pop) begin
                if (k == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
            end
            if (push) begin
                if (k == 0) q_a.push_back(d); else q_b.push_back(d);
            end
        end
    endtask

    task automatic cyc(input logic f, input logic v, input logic [31:0] d, input logic a);
        @(negedge clk_in);
        drive(f, v, d, a);
        #2;
        check_step(0, f, v, d, a);
        check_step(1, f, v, d, a);
    endtask

    task automatic check_reset(input int k);
        obs_t o;
        o = sample(k);
        check_val($sformatf("rst_ack%0d", k), 32'(o.ack), 32'h0);
        check_val($sformatf("rst_dout%0d", k), o.dout, 32'h0);
        check_val($sformatf("rst_vld%0d", k), 32'(o.vld), 32'h0);
        check_val($sformatf("rst_empty%0d", k), 32'(o.emp), 32'h1);
        check_val($sformatf("rst_aempty%0d", k), 32'(o.ae), 32'h1);
        check_val($sformatf("rst_full%0d", k), 32'(o.ful), 32'h0);
        check_val($sformatf("rst_afull%0d", k), 32'(o.af), 32'h0);
        check_val($sformatf("rst_occ%0d", k), 32'(o.occ), 32'h0);
        check_val($sformatf("rst_rej%0d", k), 32'(o.rej), 32'h0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    logic [31:0] t1 [4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC};

    initial begin
        reset_in = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        model_clear(1'b1);
        repeat (2) @(negedge clk_in);
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b1);
        #1;
        check_reset(0);
        check_reset(1);
        @(negedge clk_in);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        reset_in = 1'b0;

        // Four pushes, one pop every third cycle.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, t1[i], 1'b0);
        for (int c = 0; c < 14; c++) cyc(1'b0, 1'b0, 32'h0, (c % 3) == 2);

        // Overfill, then push+pop while full, then drain.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
        cyc(1'b0, 1'b1, 32'hAAAA_0001, 1'b1);
        cyc(1'b0, 1'b1, 32'hAAAA_0002, 1'b1);
        drain(10);

        // Randomised phases: fill-heavy, drain-heavy, balanced, with rare flushes.
        for (int i = 0; i < 1500; i++) begin
            int  ph;
            logic v;
            logic a;
            ph = i / 300;
            v  = (ph % 3 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            a  = (ph % 3 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            cyc($urandom_range(0, 40) == 0, v, $urandom, a);
        end

        // Flush with occupancy 5 and a pending push, then a push after it.
        drain(10);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 32'h500 + 32'(i), 1'b0);
        cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset between edges with occupancy 3.
        drain(6);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h600 + 32'(i), 1'b0);
        cyc(1'b0, 1'b1, 32'h0, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 32'h700 + 32'(i), 1'b0);
        drain(9);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h800 + 32'(i), 1'b0);
        @(negedge clk_in);
        drive(1'b0, 1'b1, 32'h900, 1'b0);
        #1;
        reset_in = 1'b1;
        #1;
        check_reset(0);
        check_reset(1);
        model_clear(1'b1);
        @(negedge clk_in);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        reset_in = 1'b0;

        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
